// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray counter and its downstream step monitor.
package gray_pkg;

   // Monitor FSM: PRIME waits for the synchroniser to fill, TRACK follows legal steps,
   // FAULT is entered after an illegal transition and left on an error clear.
   typedef enum logic [1:0] {
      PRIME = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } mon_state_t;

   // Number of flops each asynchronous Gray bit passes through before it is used.
   localparam int MON_SYNC_STAGES = 2;

   // Widest Gray word the shared helpers handle; narrower words are zero-extended.
   localparam int GRAY_MAX_W = 16;

   // Gray to binary: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
   // Zero-extended upper bits decode to zero, so narrow words decode correctly.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = {GRAY_MAX_W{1'b0}};
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Binary to Gray encode used by the counter that feeds the monitor.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Per-bit two-flop synchroniser with synchronous active-high reset.
// Only safe for multi-bit buses whose traffic changes one bit at a time (e.g. Gray code).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] s1_d;
   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_d;
   logic [WIDTH-1:0] s2_q;

   // Next-state for both synchroniser stages.
   always_comb begin
      s1_d = i_d;
      s2_d = s1_q;
   end

   // Synchroniser stage registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_q <= {WIDTH{1'b0}};
         s2_q <= {WIDTH{1'b0}};
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign o_q = s2_q;

endmodule

// File: rtl/gray_step_monitor.sv
// Resynchronises a Gray word into i_clk, decodes it, and classifies every change as a
// legal up step, a legal down step, or an illegal transition. Keeps saturating step and
// error counters plus a sticky fault flag for board status.
module gray_step_monitor #(
   parameter int WIDTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [WIDTH-1:0]     i_gray,
   input  logic                 i_clr_err,
   output logic [WIDTH-1:0]     o_bin,
   output logic                 o_valid,
   output logic                 o_dir,
   output logic                 o_err,
   output logic [CNT_WIDTH-1:0] o_step_cnt,
   output logic [CNT_WIDTH-1:0] o_err_cnt
);

   import gray_pkg::*;

   localparam logic [WIDTH-1:0]     BIN_ONE   = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0]     BIN_ALL   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]     BIN_ZERO  = {WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
   // PRIME holds until the synchroniser carries a real post-reset sample, so the first
   // word after reset is loaded as the reference instead of being compared to zero.
   localparam logic [1:0]           FILL_DONE = 2'(MON_SYNC_STAGES);

   // Saturating increment: counters stick at all-ones rather than wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      logic [CNT_WIDTH-1:0] r;
      if (c == CNT_MAX) begin
         r = c;
      end else begin
         r = c + CNT_ONE;
      end
      return r;
   endfunction

   // Synchronised Gray word and its decode/classification.
   logic [WIDTH-1:0]      sync_s;
   logic [GRAY_MAX_W-1:0] dec_full_s;
   logic [WIDTH-1:0]      cur_bin_s;
   logic [WIDTH-1:0]      diff_s;
   logic                  changed_s;
   logic                  step_up_s;
   logic                  step_dn_s;
   logic                  illegal_s;
   logic [CNT_WIDTH-1:0]  err_base_s;

   // Registered state.
   mon_state_t            state_d,    state_q;
   logic [1:0]            fill_d,     fill_q;
   logic [WIDTH-1:0]      prev_d,     prev_q;
   logic [WIDTH-1:0]      bin_d,      bin_q;
   logic                  valid_d,    valid_q;
   logic                  dir_d,      dir_q;
   logic                  err_d,      err_q;
   logic [CNT_WIDTH-1:0]  step_cnt_d, step_cnt_q;
   logic [CNT_WIDTH-1:0]  err_cnt_d,  err_cnt_q;

   sync_2ff #(
      .WIDTH (WIDTH)
   ) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_gray),
      .o_q   (sync_s)
   );

   // The shared decoder works on the widest supported word; the padding decodes to zero.
   generate
      if (WIDTH < GRAY_MAX_W) begin : g_dec_pad
         logic dec_pad_unused_s;
         assign dec_pad_unused_s = |dec_full_s[GRAY_MAX_W-1:WIDTH];
      end
   endgenerate

   // Decode the synchronised word and classify it against the last accepted value.
   // bin_q always equals the decode of prev_q once PRIME has completed.
   always_comb begin
      dec_full_s = gray2bin(GRAY_MAX_W'(sync_s));
      cur_bin_s  = dec_full_s[WIDTH-1:0];
      diff_s     = cur_bin_s - bin_q;
      changed_s  = (sync_s != prev_q);
      step_up_s  = changed_s && (diff_s == BIN_ONE);
      step_dn_s  = changed_s && (diff_s == BIN_ALL);
      illegal_s  = changed_s && !step_up_s && !step_dn_s;
   end

   // FSM next state, output and counter updates.
   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      prev_d     = prev_q;
      bin_d      = bin_q;
      valid_d    = 1'b0;
      dir_d      = dir_q;
      err_d      = err_q;
      step_cnt_d = step_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_base_s = err_cnt_q;

      case (state_q)
         PRIME: begin
            if (fill_q == FILL_DONE) begin
               prev_d  = sync_s;
               bin_d   = cur_bin_s;
               state_d = TRACK;
            end else begin
               fill_d = fill_q + 2'd1;
            end
         end

         TRACK, FAULT: begin
            // A clear zeroes the error count first; an illegal step in the same cycle
            // then counts on top of that, so the error always wins.
            if (i_clr_err) begin
               err_base_s = CNT_ZERO;
            end else begin
               err_base_s = err_cnt_q;
            end
            err_cnt_d = err_base_s;

            if ((state_q == FAULT) && i_clr_err) begin
               err_d   = 1'b0;
               state_d = TRACK;
            end else begin
               err_d   = err_q;
            end

            if (changed_s) begin
               prev_d = sync_s;
               bin_d  = cur_bin_s;
               if (illegal_s) begin
                  err_d     = 1'b1;
                  err_cnt_d = sat_inc(err_base_s);
                  state_d   = FAULT;
               end else begin
                  valid_d    = 1'b1;
                  dir_d      = step_up_s;
                  step_cnt_d = sat_inc(step_cnt_q);
               end
            end else begin
               prev_d = prev_q;
            end
         end

         default: begin
            state_d = PRIME;
            fill_d  = 2'd0;
         end
      endcase
   end

   // State, output and counter registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= PRIME;
         fill_q     <= 2'd0;
         prev_q     <= BIN_ZERO;
         bin_q      <= BIN_ZERO;
         valid_q    <= 1'b0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         step_cnt_q <= CNT_ZERO;
         err_cnt_q  <= CNT_ZERO;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         prev_q     <= prev_d;
         bin_q      <= bin_d;
         valid_q    <= valid_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         step_cnt_q <= step_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign o_bin      = bin_q;
   assign o_valid    = valid_q;
   assign o_dir      = dir_q;
   assign o_err      = err_q;
   assign o_step_cnt = step_cnt_q;
   assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed, table-driven bench for gray_step_monitor (WIDTH=4, CNT_WIDTH=16), plus a
// second instance with 2-bit counters to observe saturation.
module tb_gray_step_monitor;

   logic        clk;
   logic        i_rst;
   logic [3:0]  i_gray;
   logic        i_clr_err;
   logic [3:0]  o_bin;
   logic        o_valid;
   logic        o_dir;
   logic        o_err;
   logic [15:0] o_step_cnt;
   logic [15:0] o_err_cnt;

   logic [3:0]  sm_bin;
   logic        sm_valid;
   logic        sm_dir;
   logic        sm_err;
   logic [1:0]  sm_step_cnt;
   logic [1:0]  sm_err_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0]  gray;
      logic        clr;
      logic        exp_valid;
      logic [3:0]  exp_bin;
      logic        exp_dir;
      logic        exp_err;
      logic [15:0] exp_step;
      logic [15:0] exp_errcnt;
   } vec_t;

   vec_t tab_a[18];
   vec_t tab_b[8];

   gray_step_monitor #(.WIDTH(4), .CNT_WIDTH(16)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_gray     (i_gray),
      .i_clr_err  (i_clr_err),
      .o_bin      (o_bin),
      .o_valid    (o_valid),
      .o_dir      (o_dir),
      .o_err      (o_err),
      .o_step_cnt (o_step_cnt),
      .o_err_cnt  (o_err_cnt)
   );

   gray_step_monitor #(.WIDTH(4), .CNT_WIDTH(2)) dut_small (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_gray     (i_gray),
      .i_clr_err  (i_clr_err),
      .o_bin      (sm_bin),
      .o_valid    (sm_valid),
      .o_dir      (sm_dir),
      .o_err      (sm_err),
      .o_step_cnt (sm_step_cnt),
      .o_err_cnt  (sm_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] g, input logic c, input logic v,
                               input logic [3:0] b, input logic d, input logic e,
                               input int s, input int ec);
      vec_t r;
      r.gray = g; r.clr = c; r.exp_valid = v; r.exp_bin = b; r.exp_dir = d;
      r.exp_err = e; r.exp_step = 16'(s); r.exp_errcnt = 16'(ec);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic v, input logic [3:0] b,
                            input logic d, input logic e, input logic [15:0] s,
                            input logic [15:0] ec);
      check({tag, ".valid"},  16'(o_valid), 16'(v));
      check({tag, ".bin"},    16'(o_bin),   16'(b));
      check({tag, ".dir"},    16'(o_dir),   16'(d));
      check({tag, ".err"},    16'(o_err),   16'(e));
      check({tag, ".step"},   o_step_cnt,   s);
      check({tag, ".errcnt"}, o_err_cnt,    ec);
   endtask

   // Hold reset two edges with g on the input, check cleared outputs, then release and
   // let the monitor prime on g (two sync edges plus the loading edge).
   task automatic do_reset(input logic [3:0] g, input string tag);
      i_rst = 1'b1; i_gray = g; i_clr_err = 1'b0;
      tick(); tick();
      check_all({tag, ".rst"}, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      i_rst = 1'b0;
      tick(); tick(); tick();
   endtask

   // Present one Gray word and check the 3-cycle latency and one-cycle valid pulse.
   // The clear request (if any) is held for exactly the edge that evaluates the change.
   task automatic apply_vec(input vec_t v, input string tag);
      i_gray = v.gray;
      tick();
      check({tag, ".lat1"}, 16'(o_valid), 16'd0);
      tick();
      check({tag, ".lat2"}, 16'(o_valid), 16'd0);
      i_clr_err = v.clr;
      tick();
      i_clr_err = 1'b0;
      check_all(tag, v.exp_valid, v.exp_bin, v.exp_dir, v.exp_err, v.exp_step, v.exp_errcnt);
      tick();
      check({tag, ".pulse"}, 16'(o_valid), 16'd0);
      tick();
   endtask

   initial begin
      // Up count 1..15 then wrap to 0, followed by two down steps (15, 14).
      tab_a[0]  = mk(4'b0001, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0, 1,  0);
      tab_a[1]  = mk(4'b0011, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 2,  0);
      tab_a[2]  = mk(4'b0010, 1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 3,  0);
      tab_a[3]  = mk(4'b0110, 1'b0, 1'b1, 4'd4,  1'b1, 1'b0, 4,  0);
      tab_a[4]  = mk(4'b0111, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 5,  0);
      tab_a[5]  = mk(4'b0101, 1'b0, 1'b1, 4'd6,  1'b1, 1'b0, 6,  0);
      tab_a[6]  = mk(4'b0100, 1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 7,  0);
      tab_a[7]  = mk(4'b1100, 1'b0, 1'b1, 4'd8,  1'b1, 1'b0, 8,  0);
      tab_a[8]  = mk(4'b1101, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0, 9,  0);
      tab_a[9]  = mk(4'b1111, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 10, 0);
      tab_a[10] = mk(4'b1110, 1'b0, 1'b1, 4'd11, 1'b1, 1'b0, 11, 0);
      tab_a[11] = mk(4'b1010, 1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 12, 0);
      tab_a[12] = mk(4'b1011, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, 13, 0);
      tab_a[13] = mk(4'b1001, 1'b0, 1'b1, 4'd14, 1'b1, 1'b0, 14, 0);
      tab_a[14] = mk(4'b1000, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 15, 0);
      tab_a[15] = mk(4'b0000, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 16, 0);
      tab_a[16] = mk(4'b1000, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 17, 0);
      tab_a[17] = mk(4'b1001, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 18, 0);

      // Starting from binary 1 after reset: illegal jumps, steps in FAULT, clears.
      tab_b[0] = mk(4'b0111, 1'b0, 1'b0, 4'd5,  1'b0, 1'b1, 0, 1); // 1 -> 5 illegal
      tab_b[1] = mk(4'b0101, 1'b0, 1'b1, 4'd6,  1'b1, 1'b1, 1, 1); // legal up in FAULT
      tab_b[2] = mk(4'b0101, 1'b1, 1'b0, 4'd6,  1'b1, 1'b0, 1, 0); // clear, back to TRACK
      tab_b[3] = mk(4'b0000, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1, 1); // 6 -> 0 illegal
      tab_b[4] = mk(4'b0110, 1'b1, 1'b0, 4'd4,  1'b1, 1'b1, 1, 1); // clear + illegal: error wins
      tab_b[5] = mk(4'b0111, 1'b0, 1'b1, 4'd5,  1'b1, 1'b1, 2, 1); // legal up in FAULT
      tab_b[6] = mk(4'b0110, 1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 3, 0); // legal down + clear
      tab_b[7] = mk(4'b1111, 1'b1, 1'b0, 4'd10, 1'b0, 1'b1, 3, 1); // clear + illegal in TRACK

      i_rst = 1'b1; i_gray = 4'b0000; i_clr_err = 1'b0;

      // Reset and idle hold at zero.
      do_reset(4'b0000, "t1");
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("t1.idle[%0d].valid", i), 16'(o_valid), 16'd0);
      end
      check_all("t1.end", 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0);

      // Full up cycle with wrap, then down steps across the wrap.
      for (int i = 0; i < 18; i++) begin
         apply_vec(tab_a[i], $sformatf("ta[%0d]", i));
      end
      check("sat.step",   16'(sm_step_cnt), 16'd3);
      check("sat.bin",    16'(sm_bin),      16'd14);
      check("sat.dir",    16'(sm_dir),      16'd0);
      check("sat.err",    16'(sm_err),      16'd0);
      check("sat.errcnt", 16'(sm_err_cnt),  16'd0);
      check("sat.valid",  16'(sm_valid),    16'd0);

      // Fault handling, starting from Gray 0001.
      do_reset(4'b0001, "t4");
      check_all("t4.prime", 1'b0, 4'd1, 1'b0, 1'b0, 16'd0, 16'd0);
      for (int i = 0; i < 8; i++) begin
         apply_vec(tab_b[i], $sformatf("tb[%0d]", i));
      end
      check("sat.errcnt2", 16'(sm_err_cnt), 16'd1);

      // Mid-operation reset after five steps, then prime on Gray 0110 (binary 4).
      do_reset(4'b0000, "t6");
      for (int i = 0; i < 5; i++) begin
         apply_vec(tab_a[i], $sformatf("t6.step[%0d]", i));
      end
      i_rst = 1'b1;
      i_gray = 4'b0110;
      tick();
      check_all("t6.midrst", 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      i_rst = 1'b0;
      tick();
      tick();
      check_all("t6.fill", 1'b0, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();
      check_all("t6.prime", 1'b0, 4'd4, 1'b0, 1'b0, 16'd0, 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t6.hold[%0d].err", i), 16'(o_err), 16'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
